ctrl_tx_arb: RTL and testbench

- Parametrised successor to the system controller's UART transmit sequencer.
- Accepts framed responses from N_SRC producers (register file, ALU, status, ...), each of 1..MAX_BYTES bytes, and buffers one pending frame per source.
- Arbitrates round-robin among pending sources and feeds bytes LSB-first to the UART transmitter.
- Uses a proper busy-edge handshake, so each byte is issued exactly once.

---
 rtl/ctrl_tx_arb.sv | 145 ++++++++++++++
 tb/tb_ctrl_tx_arb.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/ctrl_tx_arb.sv
// Round-robin transmit sequencer: buffers one framed response per source and
// feeds the bytes LSB-first to a UART transmitter using a busy-edge handshake.
module ctrl_tx_arb #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned N_SRC      = 2,
  parameter int unsigned MAX_BYTES  = 2,
  parameter int unsigned LEN_W      = $clog2(MAX_BYTES + 1)
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic [N_SRC-1:0]                      src_send,
  input  logic [N_SRC*MAX_BYTES*DATA_WIDTH-1:0] src_data,
  input  logic [N_SRC*LEN_W-1:0]                src_len,
  output logic [N_SRC-1:0]                      src_ack,
  output logic [N_SRC-1:0]                      src_ovf,
  input  logic                                  uart_tx_busy,
  output logic [DATA_WIDTH-1:0]                 uart_tx_p_data,
  output logic                                  uart_tx_d_vld,
  output logic                                  ctrl_busy
);

  localparam int unsigned FrameW = MAX_BYTES * DATA_WIDTH;
  localparam int unsigned PtrW   = (N_SRC > 1) ? $clog2(N_SRC) : 1;

  typedef enum logic [1:0] {StIdle, StSend, StWaitBusy} state_e;

  state_e                  state_q;
  logic [N_SRC-1:0]        pending_q;
  logic [FrameW-1:0]       slot_q     [N_SRC];
  logic [LEN_W-1:0]        slot_len_q [N_SRC];
  logic [FrameW-1:0]       frame_q;
  logic [LEN_W-1:0]        len_q;
  logic [LEN_W-1:0]        idx_q;
  logic [PtrW-1:0]         rr_q;

  logic                    grant_vld;
  logic [PtrW-1:0]         grant_idx;
  logic [PtrW-1:0]         rr_nxt;
  logic [N_SRC-1:0]        grant_clr;
  logic [LEN_W-1:0]        len_clamp  [N_SRC];
  logic [DATA_WIDTH-1:0]   cur_byte;

  // First pending source at or after the round-robin pointer.
  always_comb begin
    int unsigned cand;
    grant_vld = 1'b0;
    grant_idx = '0;
    for (int unsigned k = 0; k < N_SRC; k++) begin
      cand = (32'(rr_q) + k) % N_SRC;
      if (!grant_vld && pending_q[cand]) begin
        grant_vld = 1'b1;
        grant_idx = PtrW'(cand);
      end
    end
    rr_nxt    = PtrW'((32'(grant_idx) + 1) % N_SRC);
    grant_clr = '0;
    if (state_q == StIdle && grant_vld) begin
      grant_clr[grant_idx] = 1'b1;
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < N_SRC; i++) begin
      len_clamp[i] = src_len[i*LEN_W +: LEN_W];
      if (32'(len_clamp[i]) > MAX_BYTES) begin
        len_clamp[i] = LEN_W'(MAX_BYTES);
      end
    end
  end

  always_comb begin
    cur_byte = '0;
    for (int unsigned k = 0; k < MAX_BYTES; k++) begin
      if (idx_q == LEN_W'(k)) begin
        cur_byte = frame_q[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= StIdle;
      pending_q      <= '0;
      frame_q        <= '0;
      len_q          <= '0;
      idx_q          <= '0;
      rr_q           <= '0;
      src_ack        <= '0;
      src_ovf        <= '0;
      uart_tx_p_data <= '0;
      uart_tx_d_vld  <= 1'b0;
      ctrl_busy      <= 1'b0;
      for (int unsigned i = 0; i < N_SRC; i++) begin
        slot_q[i]     <= '0;
        slot_len_q[i] <= '0;
      end
    end else begin
      src_ack       <= '0;
      src_ovf       <= '0;
      uart_tx_d_vld <= 1'b0;
      ctrl_busy     <= (|pending_q) || (state_q != StIdle);

      // Capture uses the pre-edge pending flags, so a source granted now still overflows.
      for (int unsigned i = 0; i < N_SRC; i++) begin
        if (src_send[i]) begin
          if (pending_q[i]) begin
            src_ovf[i] <= 1'b1;
          end else begin
            src_ack[i]    <= 1'b1;
            slot_q[i]     <= src_data[i*FrameW +: FrameW];
            slot_len_q[i] <= len_clamp[i];
          end
        end
      end
      pending_q <= (pending_q & ~grant_clr) | (src_send & ~pending_q);

      unique case (state_q)
        StIdle: begin
          if (grant_vld) begin
            frame_q <= slot_q[grant_idx];
            len_q   <= slot_len_q[grant_idx];
            idx_q   <= '0;
            rr_q    <= rr_nxt;
            state_q <= (slot_len_q[grant_idx] == '0) ? StIdle : StSend;
          end
        end
        StSend: begin
          if (!uart_tx_busy) begin
            uart_tx_p_data <= cur_byte;
            uart_tx_d_vld  <= 1'b1;
            idx_q          <= idx_q + 1'b1;
            state_q        <= StWaitBusy;
          end
        end
        StWaitBusy: begin
          if (uart_tx_busy) begin
            state_q <= (idx_q < len_q) ? StSend : StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_ctrl_tx_arb.sv
// Randomised bench for ctrl_tx_arb against a transaction-flavoured reference model.
module tb_ctrl_tx_arb;

  localparam int unsigned DW = 8;
  localparam int unsigned N  = 2;
  localparam int unsigned MB = 2;
  localparam int unsigned LW = $clog2(MB + 1);

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [N-1:0]      send = '0;
  logic [N*MB*DW-1:0] data = '0;
  logic [N*LW-1:0]   len = '0;
  logic              busy = 1'b0;
  logic [N-1:0]      src_ack, src_ovf;
  logic [DW-1:0]     uart_tx_p_data;
  logic              uart_tx_d_vld, ctrl_busy;

  ctrl_tx_arb #(.DATA_WIDTH(DW), .N_SRC(N), .MAX_BYTES(MB), .LEN_W(LW)) dut (
    .clk           (clk),
    .reset         (reset),
    .src_send      (send),
    .src_data      (data),
    .src_len       (len),
    .src_ack       (src_ack),
    .src_ovf       (src_ovf),
    .uart_tx_busy  (busy),
    .uart_tx_p_data(uart_tx_p_data),
    .uart_tx_d_vld (uart_tx_d_vld),
    .ctrl_busy     (ctrl_busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(string tag, logic [31:0] got, logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: pending slots, a queue of bytes still owed by the active frame.
  bit [N-1:0]       m_pend;
  logic [MB*DW-1:0] m_slot [N];
  int               m_len  [N];
  int               m_rr;
  logic [DW-1:0]    m_q[$];
  bit               m_active, m_wait;
  logic [N-1:0]     e_ack, e_ovf;
  logic             e_vld, e_cbusy;
  logic [DW-1:0]    e_pdata;

  int cyc = 0;
  int b_start = 0, b_end = 0, stall_until = 0;

  task automatic model_reset();
    m_pend = '0;
    for (int i = 0; i < N; i++) begin
      m_slot[i] = '0;
      m_len[i]  = 0;
    end
    m_rr = 0;
    m_q.delete();
    m_active = 0;
    m_wait   = 0;
    e_ack = '0; e_ovf = '0; e_vld = 0; e_cbusy = 0; e_pdata = '0;
  endtask

  task automatic model_edge();
    bit [N-1:0] old_pend;
    int g, c, l;
    old_pend = m_pend;
    e_cbusy  = (|old_pend) | m_active;
    e_ack = '0; e_ovf = '0; e_vld = 0;
    if (!m_active) begin
      g = -1;
      for (int k = 0; k < N; k++) begin
        c = (m_rr + k) % N;
        if (g < 0 && old_pend[c]) g = c;
      end
      if (g >= 0) begin
        m_pend[g] = 0;
        m_rr = (g + 1) % N;
        for (int b = 0; b < m_len[g]; b++) m_q.push_back(m_slot[g][b*DW +: DW]);
        m_active = (m_len[g] > 0);
        m_wait   = 0;
      end
    end else if (!m_wait) begin
      if (!busy) begin
        e_pdata = m_q.pop_front();
        e_vld   = 1;
        m_wait  = 1;
      end
    end else if (busy) begin
      m_wait = 0;
      if (m_q.size() == 0) m_active = 0;
    end
    for (int i = 0; i < N; i++) begin
      if (send[i]) begin
        if (old_pend[i]) begin
          e_ovf[i] = 1;
        end else begin
          e_ack[i]  = 1;
          m_pend[i] = 1;
          m_slot[i] = data[i*MB*DW +: MB*DW];
          l = int'(len[i*LW +: LW]);
          m_len[i] = (l > int'(MB)) ? int'(MB) : l;
        end
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_eq("src_ack", 32'(src_ack), 32'(e_ack));
    check_eq("src_ovf", 32'(src_ovf), 32'(e_ovf));
    check_eq("d_vld", 32'(uart_tx_d_vld), 32'(e_vld));
    check_eq("p_data", 32'(uart_tx_p_data), 32'(e_pdata));
    check_eq("ctrl_busy", 32'(ctrl_busy), 32'(e_cbusy));
    cyc++;
    // UART model: busy rises shortly after each strobe and holds for a while.
    if (uart_tx_d_vld) begin
      b_start = cyc + $urandom_range(0, 2);
      b_end   = b_start + $urandom_range(1, 10);
    end
    busy = (cyc >= b_start && cyc < b_end) || (cyc < stall_until);
    send = '0;
  endtask

  task automatic set_src(int i, logic [MB*DW-1:0] d, int l);
    send[i] = 1'b1;
    data[i*MB*DW +: MB*DW] = d;
    len[i*LW +: LW] = LW'(l);
  endtask

  task automatic idle(int n);
    repeat (n) step();
  endtask

  task automatic check_reset_outputs(string tag);
    check_eq({tag, "_ack"}, 32'(src_ack), 32'h0);
    check_eq({tag, "_ovf"}, 32'(src_ovf), 32'h0);
    check_eq({tag, "_vld"}, 32'(uart_tx_d_vld), 32'h0);
    check_eq({tag, "_pdata"}, 32'(uart_tx_p_data), 32'h0);
    check_eq({tag, "_cbusy"}, 32'(ctrl_busy), 32'h0);
  endtask

  task automatic do_reset();
    #1 reset = 1'b0;
    #1 check_reset_outputs("async_rst");
    model_reset();
    b_start = 0; b_end = 0; stall_until = 0;
    busy = 1'b0;
    #1 reset = 1'b1;
  endtask

  initial begin
    model_reset();
    #1 reset = 1'b0;
    #1 check_reset_outputs("rst");
    #10 reset = 1'b1;

    // Single byte, two-byte frame.
    set_src(0, 16'h00A5, 1); step(); idle(20);
    set_src(1, 16'h1234, 2); step(); idle(30);

    // Simultaneous requests, twice: source 0 wins both times.
    set_src(0, 16'h0011, 1); set_src(1, 16'h0022, 1); step(); idle(30);
    set_src(0, 16'h0011, 1); set_src(1, 16'h0022, 1); step(); idle(30);

    // Overflow while pending, then a zero-length frame.
    set_src(0, 16'h0055, 1); step();
    set_src(0, 16'h0066, 1); step(); idle(20);
    set_src(1, 16'h0077, 0); step(); idle(10);

    // Length clamp.
    set_src(0, 16'hCDAB, 3); step(); idle(30);

    // Long stall with busy held high.
    stall_until = cyc + 50; busy = 1'b1;
    set_src(0, 16'h00C3, 1); step(); idle(70);

    // Reset while waiting for busy on the first byte of a two-byte frame.
    set_src(1, 16'hBEEF, 2); step();
    for (int k = 0; k < 20 && !(m_wait && m_q.size() == 1); k++) step();
    check_eq("reach_wait_busy", 32'(m_wait && m_q.size() == 1), 32'h1);
    do_reset();
    idle(3);
    set_src(0, 16'h005A, 1); step(); idle(20);

    // Random traffic with occasional stalls and one mid-run reset.
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 5) == 0) begin
          set_src(i, (MB*DW)'($urandom), $urandom_range(0, 3));
        end
      end
      if ($urandom_range(0, 199) == 0) begin
        stall_until = cyc + $urandom_range(5, 40);
        busy = 1'b1;
      end
      step();
      if (c == 777) do_reset();
    end
    idle(40);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
